// File: rtl/dendy_pkg.sv
// dendy_pkg: constants and state encoding shared by the Dendy sprite-DMA block.
package dendy_pkg;
    localparam logic [15:0] DMA_REG = 16'h4014;
    localparam int LEN = 256;
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ALIGN0 = 3'd1,
        ST_ALIGN1 = 3'd2,
        ST_READ   = 3'd3,
        ST_WRITE  = 3'd4
    } state_t;
endpackage

// File: rtl/oam_dma.sv
// oam_dma: $4014 sprite DMA, copies one PRG page into OAM while halting the CPU.
module oam_dma
    import dendy_pkg::*;
(
    input  logic        clock25,
    input  logic        reset,
    input  logic        ce,
    input  logic [15:0] cpu_a,
    input  logic [7:0]  cpu_o,
    input  logic        cpu_w,
    input  logic [7:0]  oam_base,
    input  logic [7:0]  dma_i,
    output logic [15:0] dma_a,
    output logic [7:0]  oam_a,
    output logic [7:0]  oam_o,
    output logic        oam_w,
    output logic        halt,
    output logic        busy
);
    state_t      state_q, state_d;
    logic [7:0]  page_q, page_d, dst_q, dst_d;
    logic [7:0]  oam_a_q, oam_a_d, oam_o_q, oam_o_d;
    logic [8:0]  count_q, count_d;
    logic [15:0] dma_a_q, dma_a_d;
    logic        parity_q, odd_q, odd_d, oam_w_q, oam_w_d;

    always_ff @(posedge clock25) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            page_q   <= 8'h00;
            dst_q    <= 8'h00;
            oam_a_q  <= 8'h00;
            oam_o_q  <= 8'h00;
            count_q  <= 9'd0;
            dma_a_q  <= 16'h0000;
            parity_q <= 1'b0;
            odd_q    <= 1'b0;
            oam_w_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            page_q   <= page_d;
            dst_q    <= dst_d;
            oam_a_q  <= oam_a_d;
            oam_o_q  <= oam_o_d;
            count_q  <= count_d;
            dma_a_q  <= dma_a_d;
            parity_q <= parity_q ^ ce;
            odd_q    <= odd_d;
            oam_w_q  <= oam_w_d;
        end
    end

    // Every step is gated by ce; the write strobe is a single-clock pulse.
    always_comb begin
        state_d = state_q;
        page_d  = page_q;
        dst_d   = dst_q;
        oam_a_d = oam_a_q;
        oam_o_d = oam_o_q;
        count_d = count_q;
        dma_a_d = dma_a_q;
        odd_d   = odd_q;
        oam_w_d = 1'b0;
        if (ce) begin
            case (state_q)
                ST_IDLE: begin
                    if (cpu_w && cpu_a == DMA_REG) begin
                        page_d  = cpu_o;
                        dst_d   = oam_base;
                        count_d = 9'd0;
                        odd_d   = parity_q;
                        state_d = ST_ALIGN0;
                    end
                end
                ST_ALIGN0: state_d = odd_q ? ST_ALIGN1 : ST_READ;
                ST_ALIGN1: state_d = ST_READ;
                ST_READ: begin
                    dma_a_d = {page_q, count_q[7:0]};
                    state_d = ST_WRITE;
                end
                ST_WRITE: begin
                    oam_o_d = dma_i;
                    oam_a_d = dst_q + count_q[7:0];
                    oam_w_d = 1'b1;
                    count_d = count_q + 9'd1;
                    state_d = count_q == 9'(LEN - 1) ? ST_IDLE : ST_READ;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    assign dma_a = dma_a_q;
    assign oam_a = oam_a_q;
    assign oam_o = oam_o_q;
    assign oam_w = oam_w_q;
    assign halt  = state_q != ST_IDLE;
    assign busy  = halt;
endmodule

// File: tb/tb_oam_dma.sv
// tb_oam_dma: randomized checks of oam_dma against a page-copy reference model.
module tb_oam_dma;
    localparam logic [15:0] DMA_REG = 16'h4014;
    localparam int LEN = 256;

    logic        clock25, reset, ce, cpu_w, oam_w, halt, busy;
    logic [15:0] cpu_a, dma_a;
    logic [7:0]  cpu_o, oam_base, dma_i, oam_a, oam_o;
    logic [7:0]  prg [65536];
    logic [7:0]  oam_m [256];
    logic [7:0]  wq [$];
    int          total, bad, ticks;

    oam_dma dut (
        .clock25 (clock25),
        .reset   (reset),
        .ce      (ce),
        .cpu_a   (cpu_a),
        .cpu_o   (cpu_o),
        .cpu_w   (cpu_w),
        .oam_base(oam_base),
        .dma_i   (dma_i),
        .dma_a   (dma_a),
        .oam_a   (oam_a),
        .oam_o   (oam_o),
        .oam_w   (oam_w),
        .halt    (halt),
        .busy    (busy)
    );

    initial clock25 = 1'b0;
    always #5 clock25 = ~clock25;

    // Registered PRG RAM: data for a new address is visible two edges later.
    always @(posedge clock25) dma_i <= prg[dma_a];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic cyc(input logic c, input logic w = 1'b0, input logic [15:0] a = 16'h0000,
                       input logic [7:0] d = 8'h00);
        @(negedge clock25);
        if (oam_w === 1'b1) begin
            oam_m[oam_a] = oam_o;
            wq.push_back(oam_a);
        end
        ce = c;
        cpu_w = w;
        cpu_a = a;
        cpu_o = d;
        if (c) ticks++;
    endtask

    task automatic fill(input logic [7:0] page, input bit pat);
        for (int i = 0; i < 256; i++)
            prg[{page, 8'(i)}] = pat ? (8'(i) ^ 8'h5A) : 8'($urandom);
    endtask

    task automatic run(input logic [7:0] page, input logic [7:0] base, input bit odd,
                       input int gmin, input int gmax, input int hold_at, input int rst_at,
                       input int poke_at);
        logic [7:0]  exp_m [256];
        logic [15:0] sa;
        logic [7:0]  soa, soo;
        int          tc, g, gap, n, lim, sw;
        bit          c, held, was_rst;
        lim = rst_at < 0 ? LEN : rst_at;
        for (int i = 0; i < 256; i++) exp_m[i] = oam_m[i];
        for (int i = 0; i < lim; i++) exp_m[8'(int'(base) + i)] = prg[{page, 8'(i)}];
        wq.delete();
        oam_base = base;
        cyc(1'b0);
        if (ticks[0] != odd) begin
            cyc(1'b1);
            cyc(1'b0);
        end
        cyc(1'b1, 1'b1, DMA_REG, page);
        cyc(1'b0);
        check("halt_rise", {31'd0, halt}, 32'd1);
        check("busy_rise", {31'd0, busy}, 32'd1);
        tc = 0; g = 2; gap = $urandom_range(gmax, gmin); held = 0; n = 0; was_rst = 0;
        while (n < 6000) begin
            if (tc == hold_at && !held) begin
                held = 1;
                cyc(1'b0);
                sa = dma_a; soa = oam_a; soo = oam_o; sw = wq.size();
                repeat (20) cyc(1'b0);
                check("hold_dma_a", {16'd0, dma_a}, {16'd0, sa});
                check("hold_oam_a", {24'd0, oam_a}, {24'd0, soa});
                check("hold_oam_o", {24'd0, oam_o}, {24'd0, soo});
                check("hold_writes", wq.size(), sw);
                check("hold_halt", {31'd0, halt}, 32'd1);
                g = gap;
            end
            if (rst_at >= 0 && wq.size() == rst_at) begin
                reset = 1'b1;
                cyc(1'b0);
                reset = 1'b0;
                ticks = 0;
                was_rst = 1;
                check("rst_halt", {31'd0, halt}, 32'd0);
                check("rst_oam_w", {31'd0, oam_w}, 32'd0);
                sw = wq.size();
                repeat (30) cyc(1'b0);
                check("rst_no_writes", wq.size(), sw);
                check("rst_halt_stays", {31'd0, halt}, 32'd0);
                break;
            end
            c = g >= gap;
            if (c) begin
                g = 1;
                gap = $urandom_range(gmax, gmin);
            end else g++;
            if (c && tc == poke_at) cyc(1'b1, 1'b1, DMA_REG, ~page);
            else cyc(c);
            if (!halt) break;
            if (c) tc++;
            n++;
        end
        if (!was_rst) begin
            check("no_timeout", {31'd0, n < 6000}, 32'd1);
            check("ticks", tc, 513 + int'(odd));
            check("writes", wq.size(), LEN);
            check("first_a", {24'd0, wq[0]}, {24'd0, base});
            check("a16", {24'd0, wq[16]}, {24'd0, 8'(int'(base) + 16)});
            check("last_a", {24'd0, wq[255]}, {24'd0, 8'(int'(base) + 255)});
            cyc(1'b0);
            check("end_oam_w", {31'd0, oam_w}, 32'd0);
            check("end_busy", {31'd0, busy}, 32'd0);
        end
        for (int i = 0; i < 256; i++)
            check($sformatf("oam[%0d]", i), {24'd0, oam_m[i]}, {24'd0, exp_m[i]});
    endtask

    initial begin
        total = 0; bad = 0; ticks = 0;
        ce = 0; cpu_w = 0; cpu_a = 0; cpu_o = 0; oam_base = 0;
        for (int i = 0; i < 65536; i++) prg[i] = 8'($urandom);
        for (int i = 0; i < 256; i++) oam_m[i] = 8'($urandom);
        reset = 1'b1;
        repeat (3) cyc(1'b0);
        reset = 1'b0;
        ticks = 0;
        check("rst_halt0", {31'd0, halt}, 32'd0);
        check("rst_busy0", {31'd0, busy}, 32'd0);
        check("rst_oam_w0", {31'd0, oam_w}, 32'd0);
        check("rst_dma_a0", {16'd0, dma_a}, 32'd0);
        check("rst_oam_a0", {24'd0, oam_a}, 32'd0);
        check("rst_oam_o0", {24'd0, oam_o}, 32'd0);

        cyc(1'b1, 1'b1, 16'h4015, 8'h02);
        cyc(1'b0);
        cyc(1'b1, 1'b0, DMA_REG, 8'h02);
        repeat (10) cyc(1'b0);
        check("no_trig_halt", {31'd0, halt}, 32'd0);
        check("no_trig_writes", wq.size(), 0);

        fill(8'h02, 1'b1);
        run(8'h02, 8'h00, 1'b0, 4, 4, -1, -1, -1);
        run(8'h02, 8'h00, 1'b1, 2, 5, -1, -1, -1);
        fill(8'h03, 1'b0);
        run(8'h03, 8'hF0, 1'b0, 2, 5, -1, -1, -1);
        run(8'($urandom), 8'($urandom), 1'b1, 2, 5, 201, -1, 37);
        run(8'($urandom), 8'h00, 1'b0, 2, 5, -1, 100, -1);
        run(8'($urandom), 8'($urandom), 1'($urandom), 2, 5, -1, -1, -1);
        run(8'($urandom), 8'($urandom), 1'($urandom), 2, 4, 50, -1, 300);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
